// File: rtl/cipher_job_scheduler.sv
// cipher_job_scheduler: round-robin sharing of one encrypt and one decrypt core between two requesters.
// Define CIPHER_STATS_EN to add saturating per-op completion counters (enc_count, dec_count).
module cipher_job_scheduler #(
    parameter int CORE_LAT = 32,
    parameter int CNT_W    = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_vld,
    output logic         req0_rdy,
    input  logic         req0_op,
    input  logic [63:0]  req0_data,
    input  logic [127:0] req0_key,
    input  logic         req1_vld,
    output logic         req1_rdy,
    input  logic         req1_op,
    input  logic [63:0]  req1_data,
    input  logic [127:0] req1_key,
    output logic         rsp_vld,
    input  logic         rsp_rdy,
    output logic         rsp_id,
    output logic [63:0]  rsp_data,
    output logic         busy,
    output logic         core_clr,
    output logic [63:0]  core_din,
    output logic [127:0] core_key,
    output logic         enc_di_vld,
    output logic         dec_di_vld,
    input  logic [63:0]  enc_dout,
    input  logic [63:0]  dec_dout
`ifdef CIPHER_STATS_EN
    ,
    output logic [15:0]  enc_count,
    output logic [15:0]  dec_count
`endif
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CORE_LAT - 1);

    state_t         state_q;
    logic           last_grant_q, op_q, id_q;
    logic           rsp_vld_q, rsp_id_q, core_clr_q, enc_vld_q, dec_vld_q;
    logic [63:0]    din_q, rsp_data_q;
    logic [127:0]   key_q;
    logic [CNT_W-1:0] cnt_q;
    logic           idle, gnt, take;

    assign idle = state_q == IDLE;
    // On contention the requester that did not win last time gets the cores.
    assign gnt = (req0_vld && req1_vld) ? ~last_grant_q : req1_vld;
    assign req0_rdy = idle && req0_vld && !gnt;
    assign req1_rdy = idle && req1_vld && gnt;
    assign take = req0_rdy || req1_rdy;

    assign rsp_vld    = rsp_vld_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = !idle;
    assign core_clr   = core_clr_q;
    assign core_din   = din_q;
    assign core_key   = key_q;
    assign enc_di_vld = enc_vld_q;
    assign dec_di_vld = dec_vld_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= 1'b0;
            id_q         <= 1'b0;
            rsp_vld_q    <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            core_clr_q   <= 1'b0;
            enc_vld_q    <= 1'b0;
            dec_vld_q    <= 1'b0;
            din_q        <= '0;
            key_q        <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: if (take) begin
                    din_q        <= gnt ? req1_data : req0_data;
                    key_q        <= gnt ? req1_key : req0_key;
                    op_q         <= gnt ? req1_op : req0_op;
                    id_q         <= gnt;
                    last_grant_q <= gnt;
                    state_q      <= CLEAR;
                end
                CLEAR: begin
                    cnt_q      <= '0;
                    core_clr_q <= 1'b1;
                    enc_vld_q  <= !op_q;
                    dec_vld_q  <= op_q;
                    state_q    <= RUN;
                end
                RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        rsp_data_q <= op_q ? dec_dout : enc_dout;
                        rsp_id_q   <= id_q;
                        rsp_vld_q  <= 1'b1;
                        enc_vld_q  <= 1'b0;
                        dec_vld_q  <= 1'b0;
                        state_q    <= RESP;
                    end
                end
                RESP: if (rsp_rdy) begin
                    rsp_vld_q  <= 1'b0;
                    core_clr_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef CIPHER_STATS_EN
    logic [15:0] enc_cnt_q, dec_cnt_q;
    logic        rsp_hs;

    assign rsp_hs    = state_q == RESP && rsp_rdy;
    assign enc_count = enc_cnt_q;
    assign dec_count = dec_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            enc_cnt_q <= '0;
            dec_cnt_q <= '0;
        end else if (rsp_hs) begin
            if (!op_q && enc_cnt_q != 16'hFFFF) enc_cnt_q <= enc_cnt_q + 16'd1;
            if (op_q && dec_cnt_q != 16'hFFFF) dec_cnt_q <= dec_cnt_q + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cipher_job_scheduler.sv
// tb_cipher_job_scheduler: directed and randomized jobs checked against a behavioural arbitration/cipher model.
// Stats checks are compiled in only when CIPHER_STATS_EN is defined.
module tb_cipher_job_scheduler;
    localparam int LAT = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_vld, req0_rdy, req0_op;
    logic [63:0]  req0_data;
    logic [127:0] req0_key;
    logic         req1_vld, req1_rdy, req1_op;
    logic [63:0]  req1_data;
    logic [127:0] req1_key;
    logic         rsp_vld, rsp_rdy, rsp_id;
    logic [63:0]  rsp_data;
    logic         busy, core_clr, enc_di_vld, dec_di_vld;
    logic [63:0]  core_din, enc_dout, dec_dout;
    logic [127:0] core_key;
`ifdef CIPHER_STATS_EN
    logic [15:0]  enc_count, dec_count;
`endif

    int   vectors = 0;
    int   miscompares = 0;
    bit   last_g;
    int   enc_m, dec_m;

    always #5 clk = ~clk;

    cipher_job_scheduler #(.CORE_LAT(LAT), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .req0_vld(req0_vld), .req0_rdy(req0_rdy), .req0_op(req0_op),
        .req0_data(req0_data), .req0_key(req0_key),
        .req1_vld(req1_vld), .req1_rdy(req1_rdy), .req1_op(req1_op),
        .req1_data(req1_data), .req1_key(req1_key),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .core_clr(core_clr), .core_din(core_din), .core_key(core_key),
        .enc_di_vld(enc_di_vld), .dec_di_vld(dec_di_vld),
        .enc_dout(enc_dout), .dec_dout(dec_dout)
`ifdef CIPHER_STATS_EN
        , .enc_count(enc_count), .dec_count(dec_count)
`endif
    );

    function automatic logic [63:0] enc_f(input logic [63:0] d, input logic [127:0] k);
        logic [63:0] x;
        x = d ^ k[63:0];
        return {x[55:0], x[63:56]} + k[127:64];
    endfunction

    function automatic logic [63:0] dec_f(input logic [63:0] c, input logic [127:0] k);
        logic [63:0] x;
        x = c - k[127:64];
        return {x[7:0], x[63:8]} ^ k[63:0];
    endfunction

    // Core stand-ins: a valid result only while the matching core is enabled, junk otherwise.
    assign enc_dout = (enc_di_vld && core_clr) ? enc_f(core_din, core_key) : 64'hDEAD_BEEF_0BAD_F00D;
    assign dec_dout = (dec_di_vld && core_clr) ? dec_f(core_din, core_key) : 64'hFEED_FACE_BAAD_CAFE;

    function automatic logic [63:0] r64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [127:0] r128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input bit r, input bit op, input logic [63:0] d, input logic [127:0] k);
        if (r) begin
            req1_vld = 1'b1; req1_op = op; req1_data = d; req1_key = k;
        end else begin
            req0_vld = 1'b1; req0_op = op; req0_data = d; req0_key = k;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_vld = 1'b0; req1_vld = 1'b0; rsp_rdy = 1'b0;
        tick();
        tick();
        chk("rst_rsp_vld", 128'(rsp_vld), 128'(0));
        chk("rst_rsp_id", 128'(rsp_id), 128'(0));
        chk("rst_rsp_data", 128'(rsp_data), 128'(0));
        chk("rst_core_clr", 128'(core_clr), 128'(0));
        chk("rst_core_din", 128'(core_din), 128'(0));
        chk("rst_core_key", core_key, 128'(0));
        chk("rst_di_vld", 128'({enc_di_vld, dec_di_vld}), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        reset = 1'b0;
        last_g = 1'b1;
        enc_m = 0;
        dec_m = 0;
    endtask

    // Called in an IDLE cycle with at least one request pending; returns at the next IDLE cycle.
    task automatic job(input int bp, input bit early, input bit keep, output bit gid, output logic [63:0] got);
        bit g, op, bad;
        logic [63:0] d, exp;
        logic [127:0] k;
        int ne, nd, n;
        #1;
        g = (req0_vld && req1_vld) ? !last_g : req1_vld;
        chk("rdy0", 128'(req0_rdy), 128'(!g));
        chk("rdy1", 128'(req1_rdy), 128'(g));
        d = g ? req1_data : req0_data;
        k = g ? req1_key : req0_key;
        op = g ? req1_op : req0_op;
        exp = op ? dec_f(d, k) : enc_f(d, k);
        last_g = g;
        rsp_rdy = early;
        tick();
        load(g, 1'($urandom_range(1)), r64(), r128());
        if (!keep) begin
            if (g) req1_vld = 1'b0;
            else req0_vld = 1'b0;
        end
        chk("clear_clr", 128'(core_clr), 128'(0));
        chk("clear_busy", 128'(busy), 128'(1));
        bad = req0_rdy || req1_rdy;
        ne = 0; nd = 0; n = 0;
        while (!rsp_vld && n < 100) begin
            tick();
            n++;
            ne += int'(enc_di_vld);
            nd += int'(dec_di_vld);
            if (req0_rdy || req1_rdy || !busy) bad = 1'b1;
            if ((enc_di_vld || dec_di_vld) && !core_clr) bad = 1'b1;
        end
        chk("latency", 128'(n), 128'(LAT + 1));
        chk("enc_cycles", 128'(ne), 128'(op ? 0 : LAT));
        chk("dec_cycles", 128'(nd), 128'(op ? LAT : 0));
        chk("busy_rdy_run", 128'(bad), 128'(0));
        chk("rsp_id", 128'(rsp_id), 128'(g));
        chk("rsp_data", 128'(rsp_data), 128'(exp));
        gid = rsp_id;
        got = rsp_data;
        if (!early) begin
            bad = 1'b0;
            repeat (bp) begin
                tick();
                if (!rsp_vld || rsp_data !== exp || rsp_id !== g || req0_rdy || req1_rdy) bad = 1'b1;
                if (enc_di_vld || dec_di_vld || !core_clr) bad = 1'b1;
            end
            chk("bp_hold", 128'(bad), 128'(0));
            rsp_rdy = 1'b1;
        end
        tick();
        chk("rsp_drop", 128'(rsp_vld), 128'(0));
        chk("idle_busy", 128'(busy), 128'(0));
        rsp_rdy = 1'b0;
        if (op) dec_m++;
        else enc_m++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit gid, seen;
        logic [63:0] got, c;
        req0_op = 1'b0; req0_data = '0; req0_key = '0;
        req1_op = 1'b0; req1_data = '0; req1_key = '0;
        do_reset();

        load(0, 1'b0, 64'h0, 128'h1);
        job(0, 1'b1, 1'b0, gid, c);
        load(1, 1'b1, c, 128'h1);
        job(0, 1'b1, 1'b0, gid, got);
        chk("roundtrip_data", 128'(got), 128'(0));
        chk("roundtrip_id", 128'(gid), 128'(1));

        do_reset();
        load(0, 1'b0, r64(), r128());
        load(1, 1'b1, r64(), r128());
        for (int j = 0; j < 4; j++) begin
            job(0, 1'b1, 1'b1, gid, got);
            chk($sformatf("grant_%0d", j), 128'(gid), 128'(j % 2));
        end

        job(50, 1'b0, 1'b0, gid, got);
        job(3, 1'b0, 1'b0, gid, got);

        load(0, 1'b0, r64(), r128());
        #1;
        chk("abort_rdy", 128'(req0_rdy), 128'(1));
        tick();
        req0_vld = 1'b0;
        repeat (11) tick();
        chk("abort_running", 128'(enc_di_vld), 128'(1));
        reset = 1'b1;
        tick();
        chk("abort_rsp_vld", 128'(rsp_vld), 128'(0));
        chk("abort_clr", 128'(core_clr), 128'(0));
        chk("abort_di_vld", 128'({enc_di_vld, dec_di_vld}), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        reset = 1'b0;
        last_g = 1'b1;
        enc_m = 0;
        dec_m = 0;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (rsp_vld || busy) seen = 1'b1;
        end
        chk("abort_no_rsp", 128'(seen), 128'(0));
        load(0, 1'b0, r64(), r128());
        load(1, 1'b1, r64(), r128());
        job(0, 1'b1, 1'b0, gid, got);
        chk("after_abort_id", 128'(gid), 128'(0));
        job(0, 1'b1, 1'b0, gid, got);

        for (int i = 0; i < 30; i++) begin
            if (!req0_vld && $urandom_range(1) == 1) load(0, 1'($urandom_range(1)), r64(), r128());
            if (!req1_vld && $urandom_range(1) == 1) load(1, 1'($urandom_range(1)), r64(), r128());
            if (!req0_vld && !req1_vld) load(1'($urandom_range(1)), 1'($urandom_range(1)), r64(), r128());
            job($urandom_range(5), 1'($urandom_range(1)), 1'($urandom_range(1)), gid, got);
        end
        req0_vld = 1'b0;
        req1_vld = 1'b0;
        tick();

`ifdef CIPHER_STATS_EN
        chk("enc_count", 128'(enc_count), 128'(enc_m));
        chk("dec_count", 128'(dec_count), 128'(dec_m));
        do_reset();
        chk("count_rst", 128'({enc_count, dec_count}), 128'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cipher_job_scheduler.md
Name: cipher_job_scheduler

Overview:
- Shares one encrypt core and one decrypt core (64-bit block, 128-bit key, active-low clr, level di_vld, fixed-latency dout) between two requesters: keyboard/UI path (req0) and the debug/test path (req1).
- Arbitrates round-robin, loads operands, clears and runs the selected core for a fixed latency, captures dout, and returns the result over a valid/ready response port.
- Sits between the top-level control logic and the cipher cores.

Parameters:
- CORE_LAT, 32: cycles di_vld is held high before core dout is valid.
- CNT_W, 6: width of the internal run counter; must satisfy 2^CNT_W > CORE_LAT.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_vld  in  1  requester 0 has a job.
- req0_rdy  out  1  job accepted this cycle.
- req0_op  in  1  0 = encrypt, 1 = decrypt.
- req0_data  in  64  plaintext or ciphertext.
- req0_key  in  128  key.
- req1_vld, req1_rdy, req1_op, req1_data, req1_key: same as req0, for requester 1.
- rsp_vld  out  1  result valid.
- rsp_rdy  in  1  consumer accepts result.
- rsp_id  out  1  requester index of the result.
- rsp_data  out  64  core output.
- busy  out  1  high in any state except IDLE.
- core_clr  out  1  active-low clear to both cores.
- core_din  out  64  latched data to both cores.
- core_key  out  128  latched key to both cores.
- enc_di_vld  out  1  encrypt core valid.
- dec_di_vld  out  1  decrypt core valid.
- enc_dout  in  64  encrypt core result.
- dec_dout  in  64  decrypt core result.

Behaviour:
- Reset values: state=IDLE, rsp_vld=0, rsp_id=0, rsp_data=0, core_clr=0, core_din=0, core_key=0, enc_di_vld=0, dec_di_vld=0, busy=0, last_grant=1 (req0 wins first).
- IDLE:
  - core_clr=0.
  - reqN_rdy is combinational and high only for the granted requester.
  - Grant rule: only one vld → that requester. Both vld → the requester != last_grant.
  - On handshake (vld & rdy): latch op, data, key and id into core_din/core_key/op_q/id_q; last_grant<=id; go CLEAR.
- CLEAR: 1 cycle; core_clr=0, both di_vld=0; counter<=0; go RUN.
- RUN:
  - core_clr=1. enc_di_vld=!op_q, dec_di_vld=op_q; the other di_vld stays 0.
  - Counter increments each cycle.
  - In the cycle counter==CORE_LAT-1: rsp_data<=(op_q ? dec_dout : enc_dout), rsp_id<=id_q, rsp_vld<=1; go RESP.
- RESP:
  - Both di_vld=0, core_clr=1; rsp_data/rsp_id held stable.
  - On rsp_rdy: rsp_vld<=0; go IDLE.
- Latency: handshake at cycle T → rsp_vld first high at T+CORE_LAT+2.
- reqN_rdy is low in CLEAR, RUN and RESP. Requests arriving then wait; requesters hold vld and operands stable until rdy.
- Back-pressure: rsp_rdy low holds RESP indefinitely; no new job is accepted.
- rsp_rdy high in the same cycle rsp_vld rises: that is the handshake cycle; rsp_vld drops the next cycle.
- After return to IDLE, a pending job is accepted in that IDLE cycle (one-cycle bubble minimum between jobs).
- Reset asserted mid-operation: job aborted, no response, all outputs to reset values the next edge. last_grant resets to 1.
- Changes to reqN_* after acceptance do not affect the running job.

Optional Feature:
- Macro: CIPHER_STATS_EN.
- Defined: adds outputs enc_count[15:0] and dec_count[15:0].
  - Each increments on the response handshake of the matching op.
  - Saturates at 16'hFFFF; cleared by reset.
- Undefined: the ports and counters do not exist.

Test Plan:
- Reset then single encrypt: req0 op=0, data=64'h0, key=128'h1 → req0_rdy one cycle; busy high; enc_di_vld high exactly 32 cycles; dec_di_vld never high; rsp_vld at T+34, rsp_id=0, rsp_data=enc_dout sampled in the last RUN cycle.
- Round trip: req1 decrypt of the previous rsp_data with key 128'h1 → rsp_id=1, rsp_data=64'h0.
- Contention: req0 and req1 both valid from reset → grants in order 0, 1, 0, 1 over four jobs; the non-granted requester's rdy stays low until the scheduler returns to IDLE.
- Back-pressure: rsp_rdy held low 50 cycles after rsp_vld → rsp_vld/rsp_data stable, req rdy low throughout; rsp_rdy pulse → rsp_vld low the next cycle.
- Reset at RUN cycle 10 → no rsp_vld, core_clr=0, di_vld=0 the next edge; next job from req0 completes normally.
- With CIPHER_STATS_EN: 3 encrypts and 2 decrypts completed → enc_count=3, dec_count=2. Preloaded at 16'hFFFF, one more encrypt → enc_count stays 16'hFFFF.
